// File: rtl/xor5_parity_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the XOR5 parity pipe.
// Sized for the largest supported requester count (8); narrower instances zero-extend.
package xor5_parity_arb_pkg;

    localparam int OPW   = 5;
    localparam int STATW = 16;
    localparam int NMAX  = 8;
    localparam int IDW   = 3;

    typedef struct packed {
        logic           v;
        logic           parity;
        logic [IDW-1:0] id;
    } stage_t;

    // One-hot pick of the first set valid bit at or above ptr, wrapping modulo n.
    function automatic logic [NMAX-1:0] rr_pick(input logic [NMAX-1:0] valid,
                                                input logic [IDW-1:0]  ptr,
                                                input int              n);
        logic [NMAX-1:0] g;
        logic            found;
        logic [IDW:0]    idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NMAX; k++) begin
            if (k < n) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'(n)) idx = idx - 4'(n);
                if (!found && valid[idx[IDW-1:0]]) begin
                    g[idx[IDW-1:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/xor5_parity_arb_if.sv
// Requester, result and statistics signals of the shared parity arbiter.
// master = producers/consumer side, slave = arbiter side.
interface xor5_parity_arb_if
    import xor5_parity_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int OIDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [OPW*NREQ-1:0]   req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_parity;
    logic [OIDW-1:0]       out_id;
    logic                  out_ready;
    logic [STATW*NREQ-1:0] stat_grants;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_parity, out_id, stat_grants
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_parity, out_id, stat_grants
    );

endinterface

// File: rtl/xor5_parity_arbiter_pipe.sv
// Shared XOR5 parity datapath: LAT register stages of {v, parity, id}.
// Latency LAT advancing cycles; when adv is low every stage (bubbles too) holds.
// Backpressure is applied by the caller through adv.
module xor5_parity_pipe
    import xor5_parity_arb_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   adv,
    input  stage_t din,
    output stage_t dout
);

    stage_t st [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) st[k] <= '0;
        end else if (adv) begin
            st[0] <= din;
            for (int k = 1; k < LAT; k++) st[k] <= st[k-1];
        end
    end

    assign dout = st[LAT-1];

endmodule

// File: rtl/xor5_parity_arbiter.sv
// Round-robin arbiter sharing one pipelined XOR5 parity unit among NREQ requesters.
// Latency LAT cycles from grant to out_valid, plus one per stall cycle.
// Grants only when the pipe advances (!out_valid | out_ready); XOR5_PARITY_ARB_STATS_EN adds grant counters.
module xor5_parity_arbiter
    import xor5_parity_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    xor5_parity_arb_if.slave   bus
);

    localparam int OIDW = $clog2(NREQ);

    logic            adv;
    logic [NMAX-1:0] valid_w;
    logic [NMAX-1:0] grant_w;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic            par;
    stage_t          s_in;
    stage_t          s_out;
    logic            unused_id;

    assign adv = !bus.out_valid || bus.out_ready;

    always_comb begin
        valid_w             = '0;
        valid_w[NREQ-1:0]   = bus.req_valid;
    end

    assign grant_w   = (adv && !rst) ? rr_pick(valid_w, ptr, NREQ) : '0;
    assign grant     = grant_w[NREQ-1:0];
    assign grant_any = |grant_w;
    assign bus.req_ready = grant;

    // Bubbles carry zero parity/id so idle outputs stay at their reset values.
    always_comb begin
        gid = '0;
        par = 1'b0;
        for (int i = 0; i < NMAX; i++) begin
            if (grant_w[i]) gid = IDW'(i);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) par = par | (^bus.req_data[OPW*i +: OPW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (gid == IDW'(NREQ-1)) ? '0 : gid + 3'd1;
        end
    end

    assign s_in = '{v: grant_any, parity: par, id: gid};

    xor5_parity_pipe #(.LAT(LAT)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .din  (s_in),
        .dout (s_out)
    );

    assign bus.out_valid  = s_out.v;
    assign bus.out_parity = s_out.parity;
    assign bus.out_id     = s_out.id[OIDW-1:0];
    assign unused_id      = ^s_out.id;

`ifdef XOR5_PARITY_ARB_STATS_EN
    logic [STATW-1:0] cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && cnt[i] != {STATW{1'b1}}) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) bus.stat_grants[STATW*i +: STATW] = cnt[i];
    end
`else
    assign bus.stat_grants = '0;
`endif

endmodule

// File: tb/tb_xor5_parity_arbiter.sv
// Randomized bench: an ordered queue of accepted operands stands in for the shared parity unit.
module tb_xor5_parity_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int DW   = 5 * NREQ;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor5_parity_arb_if #(.NREQ(NREQ)) bus ();

    xor5_parity_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic par;
        int   id;
        int   tag;
    } ent_t;

    ent_t q[$];
    int   ptr;
    int   adv_cnt;
    int   cnt[NREQ];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr     = 0;
        adv_cnt = 0;
        foreach (cnt[i]) cnt[i] = 0;
    endtask

    // One clock: drive, check against the model, then move the model across the edge.
    task automatic cycle(input logic r, input logic [NREQ-1:0] v, input logic [DW-1:0] d,
                         input logic ordy);
        logic            ev;
        logic            adv;
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   es;
        int              gi;
        ent_t            e;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        #1;
        ev  = (q.size() > 0) && (adv_cnt - q[0].tag == LAT);
        adv = !ev || ordy;
        eg  = '0;
        gi  = -1;
        if (!r && adv) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (gi < 0 && v[i]) begin
                    gi    = i;
                    eg[i] = 1'b1;
                end
            end
        end
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        if (ev) begin
            chk("out_parity", 64'(bus.out_parity), 64'(q[0].par));
            chk("out_id", 64'(bus.out_id), 64'(q[0].id));
        end
`ifdef XOR5_PARITY_ARB_STATS_EN
        es = '0;
        for (int i = 0; i < NREQ; i++) es[16*i +: 16] = 16'(cnt[i]);
        chk("stat_grants", 64'(bus.stat_grants), 64'(es));
`else
        es = '0;
        chk("stat_zero", 64'(bus.stat_grants), 64'(es));
`endif
        if (r) begin
            model_reset();
        end else if (adv) begin
            if (ev) void'(q.pop_front());
            if (gi >= 0) begin
                e.par = ^d[5*gi +: 5];
                e.id  = gi;
                e.tag = adv_cnt;
                q.push_back(e);
                ptr = (gi + 1) % NREQ;
                if (cnt[gi] < 65535) cnt[gi]++;
            end
            adv_cnt++;
        end
    endtask

    initial begin
        logic [DW-1:0] d;

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_parity", 64'(bus.out_parity), 64'd0);
        chk("rst_out_id", 64'(bus.out_id), 64'd0);
        chk("rst_stat", 64'(bus.stat_grants), 64'd0);
        model_reset();

        // Lone request from requester 2 with operand 10110.
        d        = '0;
        d[14:10] = 5'b10110;
        cycle(1'b0, 4'b0100, d, 1'b1);
        repeat (4) cycle(1'b0, 4'b0000, DW'($urandom), 1'b1);

        // All requesters busy: strict rotation, one result per cycle.
        repeat (40) cycle(1'b0, 4'b1111, DW'($urandom), 1'b1);

        // Fill, stall five cycles, release.
        repeat (3) cycle(1'b0, 4'b1111, DW'($urandom), 1'b1);
        repeat (5) cycle(1'b0, 4'b1111, DW'($urandom), 1'b0);
        repeat (6) cycle(1'b0, 4'b1111, DW'($urandom), 1'b1);

        // Drive ptr to 3, then requesters 3 and 0 to exercise the wrap.
        repeat (4) cycle(1'b0, 4'b0000, DW'($urandom), 1'b1);
        cycle(1'b0, 4'b0100, DW'($urandom), 1'b1);
        repeat (2) cycle(1'b0, 4'b1001, DW'($urandom), 1'b1);
        cycle(1'b0, 4'b0110, DW'($urandom), 1'b1);

        // Reset with entries in flight: nothing may emerge afterwards.
        repeat (2) cycle(1'b0, 4'b1111, DW'($urandom), 1'b1);
        cycle(1'b1, 4'b1111, DW'($urandom), 1'b1);
        repeat (4) cycle(1'b0, 4'b0000, DW'($urandom), 1'b1);

        // Random traffic, backpressure and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 199) == 0, NREQ'($urandom), DW'($urandom),
                  $urandom_range(0, 3) != 0);
        end

`ifdef XOR5_PARITY_ARB_STATS_EN
        cycle(1'b1, 4'b0000, DW'($urandom), 1'b1);
        for (int n = 0; n < 70000; n++) cycle(1'b0, 4'b0010, DW'($urandom), 1'b1);
        @(negedge clk);
        #1;
        chk("stat1_saturated", 64'(bus.stat_grants[31:16]), 64'h0000_0000_0000_FFFF);
        chk("stat_others_idle", 64'({bus.stat_grants[63:32], bus.stat_grants[15:0]}), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xor5_parity_arbiter.md
# xor5_parity_arbiter

Round-robin arbiter and sequencer that shares one pipelined 5-input XOR parity unit among NREQ requesters. Each requester offers a 5-bit operand with a valid/ready handshake. At most one operand is granted per cycle, and the block tags it with the requester index. It returns the parity result with that tag after a fixed pipeline latency. The block sits between operand producers and a single result consumer, and it is the only path into the shared parity datapath.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- LAT, 2: parity pipeline depth in cycles, 1..4; models the clock-zone count of the shared unit.

Ports:
- clk, input, 1: rising-edge clock. One clock domain only.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, NREQ: per-requester operand valid.
- req_data, input, 5*NREQ: operands; requester i uses bits [5i+4:5i].
- req_ready, output, NREQ: one-hot or zero grant; asserted in the cycle the operand is accepted.
- out_valid, output, 1: result valid.
- out_parity, output, 1: XOR of all 5 bits of the granted operand.
- out_id, output, $clog2(NREQ): index of the requester that supplied the operand.
- out_ready, input, 1: consumer accepts the result.
- stat_grants, output, 16*NREQ: per-requester grant counters (see Configuration).

## Operation
- Transfer on requester i: req_valid[i] & req_ready[i] in the same cycle.
- Round-robin pointer ptr, reset 0:
  - Search starts at ptr and proceeds upward, wrapping modulo NREQ.
  - The first asserted req_valid wins.
  - After a grant to i, ptr ← (i+1) mod NREQ.
  - With no grant, ptr holds.
- A grant is issued only when the pipeline advances this cycle (adv). req_ready is zero otherwise.
- adv = !out_valid | out_ready.
- Pipeline: LAT stages, each holding {v, parity, id}.
  - On adv: stage0 ← {grant_any, ^operand, grant_id}, and stage k ← stage k-1.
  - When !adv: all stages hold, including bubbles. A stall never drops or duplicates an entry.
- Outputs are driven by the last stage: out_valid = v, plus its parity and id.
- out_parity is bitwise XOR; data bits never influence arbitration.
- The block never accepts an operand that cannot eventually be delivered; there is no internal overflow.

## Timing
- Reset values:
  - req_ready = 0 (all bits).
  - out_valid = 0, out_parity = 0, out_id = 0.
  - ptr = 0.
  - All stage valids 0.
  - stat_grants = 0.
- Latency: a request accepted at cycle t produces out_valid at t+LAT when no stalls occur. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle while out_ready stays high.
- req_ready is combinational from req_valid, ptr and out_valid/out_ready. No combinational path exists from req_data to any output.
- Reset asserted mid-operation: all in-flight entries are discarded. The first cycle after rst deasserts behaves as post-reset. Results are not delivered for operands accepted before reset.
- A requester may drop req_valid without a grant; no state is kept per requester.

## Configuration
- XOR5_PARITY_ARB_STATS_EN defined:
  - Each 16-bit field of stat_grants counts accepted transfers for its requester.
  - Counters saturate at 16'hFFFF and clear on rst.
- Macro undefined:
  - Counters are not built.
  - stat_grants is tied to 0.
  - All other behaviour is identical.

## Structure
- Package xor5_parity_arb_pkg holds:
  - OPW = 5 constant.
  - Stat counter width 16.
  - Typedef stage_t {logic v; logic parity; logic [IDW-1:0] id;}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module xor5_parity_pipe (LAT stages, advance enable, stage_t in/out) holds the shared datapath. The top level holds the arbiter, the pointer and the optional counters.

## Test plan
- Reset then single request: req_valid=4'b0100, data 5'b10110, out_ready=1 → req_ready=4'b0100 at t. At t+2: out_valid=1, out_parity=1, out_id=2.
- All four requesters valid continuously, out_ready=1 → grants in order 0,1,2,3,0,…; one result per cycle; parities match the operands.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles → req_ready=0 throughout, outputs stable. On release, results appear in order with none lost.
- Fairness wrap: ptr=3, req_valid=4'b1001 → grant 3 then 0, and ptr returns to 1.
- Reset mid-stream with 2 entries in flight → no out_valid after reset until a new accept plus LAT cycles.
- With XOR5_PARITY_ARB_STATS_EN: issue 70000 grants to requester 1 → stat_grants field 1 = 16'hFFFF, other fields unchanged. Without the macro → stat_grants = 0.
